// File: rtl/calc_pkg.sv
// calc_pkg: shared FSM encoding, default sizes and the per-nibble add-3 rule
// for the accumulator BCD reader.
package calc_pkg;
    localparam int WIDTH_DEF  = 32;
    localparam int DIGITS_DEF = 10;
    typedef enum logic [1:0] {IDLE, CONVERT, SEND} state_e;
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction
endpackage

// File: rtl/dabble_step.sv
// dabble_step: one double-dabble iteration -- add 3 to every nibble >= 5,
// then shift the whole BCD register left by one, bringing in the next magnitude bit.
module dabble_step import calc_pkg::*; #(
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic [4*DIGITS-1:0] bcd_i,
    input  logic                bit_i,
    output logic [4*DIGITS-1:0] bcd_o
);
    logic [4*DIGITS-1:0] adj;
    genvar i;
    for (i = 0; i < DIGITS; i++) begin : g_adj
        assign adj[4*i +: 4] = add3(bcd_i[4*i +: 4]);
    end
    assign bcd_o = {adj[4*DIGITS-2:0], bit_i};
endmodule

// File: rtl/accum_bcd_reader.sv
// accum_bcd_reader: captures a signed accumulator value, converts |value| to BCD
// serially and streams the digits MSD first over a valid/ready handshake.
module accum_bcd_reader import calc_pkg::*; #(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    input  logic             start,
    output logic             busy,
    output logic             sign,
    output logic [3:0]       digit,
    output logic             digit_valid,
    input  logic             digit_ready,
    output logic             digit_last
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int IW = $clog2(DIGITS + 1);
    state_e              state_q;
    logic [WIDTH-1:0]    mag_q;
    logic [4*DIGITS-1:0] bcd_q;
    logic [4*DIGITS-1:0] bcd_d;
    logic [CW-1:0]       cnt_q;
    logic [IW-1:0]       idx_q;
    logic                sign_q;
    logic                valid_q;
    logic                last_q;
    dabble_step #(.DIGITS(DIGITS)) u_step (
        .bcd_i(bcd_q),
        .bit_i(mag_q[WIDTH-1]),
        .bcd_o(bcd_d)
    );
    // cnt_q runs 0..WIDTH: WIDTH iterations, then one edge to present the first digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mag_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            sign_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_q <= CONVERT;
                    sign_q  <= value[WIDTH-1];
                    mag_q   <= value[WIDTH-1] ? -value : value;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                end
                CONVERT: if (cnt_q == CW'(WIDTH)) begin
                    state_q <= SEND;
                    valid_q <= 1'b1;
                    last_q  <= (DIGITS == 1);
                    idx_q   <= '0;
                end else begin
                    bcd_q <= bcd_d;
                    mag_q <= mag_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                end
                SEND: if (digit_ready) begin
                    bcd_q <= bcd_q << 4;
                    if (last_q) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                        last_q <= (idx_q == IW'(DIGITS - 2));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign busy        = (state_q != IDLE);
    assign sign        = sign_q;
    assign digit       = bcd_q[4*DIGITS-1 -: 4];
    assign digit_valid = valid_q;
    assign digit_last  = last_q;
endmodule

// File: doc/accum_bcd_reader.md
ACCUM_BCD_READER -- requirements
Module: accum_bcd_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the accumulator word width in two's complement.
REQ-002 SHALL have parameter DIGITS, default 10, the number of BCD digits emitted per value.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port value  input  WIDTH  the accumulator output to convert, signed.
REQ-006 SHALL have port start  input  1  request to capture value and begin a conversion.
REQ-007 SHALL have port busy  output  1  high from capture until the last digit is accepted.
REQ-008 SHALL have port sign  output  1  high when the captured value was negative.
REQ-009 SHALL have port digit  output  4  current BCD digit, most significant digit first.
REQ-010 SHALL have port digit_valid  output  1  digit is presented.
REQ-011 SHALL have port digit_ready  input  1  consumer accepts digit when high with digit_valid.
REQ-012 SHALL have port digit_last  output  1  high with digit_valid on the final (least significant) digit.

Function
REQ-013 SHALL implement states IDLE, CONVERT and SEND.
REQ-014 In IDLE with start high, the block SHALL, at that edge, capture sign = value[WIDTH-1] and magnitude = |value| as a WIDTH-bit unsigned (0x80000000 maps to 2147483648), then enter CONVERT.
REQ-015 start SHALL be ignored outside IDLE; value SHALL be sampled only at the capture edge.
REQ-016 CONVERT SHALL run exactly WIDTH shift-add-3 (double-dabble) iterations, one per cycle, then enter SEND.
REQ-017 The block SHALL assert digit_valid on the cycle after the last iteration, i.e. WIDTH+1 edges after the capture edge.
REQ-018 SEND SHALL emit DIGITS digits, leading zeros included; there SHALL be no zero suppression.
REQ-019 A digit SHALL transfer only on an edge where digit_valid and digit_ready are both high.
REQ-020 While digit_valid is high and digit_ready is low, digit and digit_last SHALL stay stable.
REQ-021 After the transfer of the last digit, the block SHALL return to IDLE, drop busy and digit_valid at that edge, and be able to accept start on the next edge.
REQ-022 start high on the same edge as the final transfer SHALL be ignored.
REQ-023 sign SHALL hold its value from capture until the next capture.
REQ-024 DIGITS SHALL be at least ceil(WIDTH*log10(2)); with the defaults, 10 digits cover 2147483648.

Reset
REQ-025 While rst_n is low, the block SHALL immediately, without a clock edge, be in IDLE with busy=0, sign=0, digit=0, digit_valid=0 and digit_last=0, and all conversion registers cleared.
REQ-026 Reset asserted during CONVERT or SEND SHALL abort the conversion; no partial digits SHALL be emitted after release.
REQ-027 After reset deasserts, the first start SHALL be honoured on the first rising edge.

Structure
REQ-028 The state encoding and the WIDTH and DIGITS defaults SHALL live in the shared package calc_pkg.
REQ-029 One combinational sub-module SHALL be used: dabble_step, which applies add-3 to each BCD nibble ≥5 and shifts in one magnitude bit.
REQ-030 The digit output SHALL come from the registered BCD shift register (top nibble, shifted left 4 per transfer), not from combinational logic on value.

Verification
REQ-031 value=0, start, digit_ready=1 -> sign=0; digits 0,0,0,0,0,0,0,0,0,0; digit_last on the 10th; first valid 33 edges after capture.
REQ-032 value=1234567890 -> sign=0; digits 1,2,3,4,5,6,7,8,9,0.
REQ-033 value=0xFFFFFFFF -> sign=1; digits 0,0,0,0,0,0,0,0,0,1. value=0x80000000 -> sign=1; digits 2,1,4,7,4,8,3,6,4,8.
REQ-034 value=987, digit_ready low for 3 cycles while digit 8 (position 9) is presented -> digit stays 8 for those cycles; stream 0,…,0,9,8,7 arrives with no loss or duplication.
REQ-035 start pulsed with value=5 during CONVERT of value=42 -> only 42 is emitted; busy falls on the final transfer edge.
REQ-036 rst_n low for 1 cycle mid-SEND -> outputs cleared immediately, state IDLE; the next start with value=7 yields a clean 0,…,0,7.
